// File: rtl/button_event_gen.sv
// button_event_gen: turns DW debounced button levels into PRESS/RELEASE/LONG/REPEAT
// events. There is one small FSM per bit, timed in en_i ticks. Each event raises a
// per-bit/per-type pending flag, and the flags are drained one at a time over valid/ready.
// Build option: define BTN_EVT_REPEAT_EN to emit REPEAT events while a button is held.
module button_event_gen #(
  parameter int DW               = 4,
  parameter int LONG_PRESS_COUNT = 1000,
  parameter int REPEAT_COUNT     = 200,
  localparam int IDX_W           = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DW-1:0]    in,
  input  logic             evt_ready,
  input  logic             ovf_clr_i,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic [1:0]       evt_type,
  output logic             ovf_o
);

  localparam int MAXC = (LONG_PRESS_COUNT > REPEAT_COUNT) ? LONG_PRESS_COUNT : REPEAT_COUNT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_PRESS_COUNT);
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CW-1:0] REP_C   = CW'(REPEAT_COUNT);
`endif

  typedef enum logic [1:0] {IDLE, DOWN, HELD} state_t;

  // Per-lane event strobes, one bit per type: [0] PRESS [1] RELEASE [2] LONG [3] REPEAT
  logic [DW-1:0][3:0] set_evt;
  logic [DW-1:0][3:0] pend;
  logic [DW-1:0][3:0] clr;

  for (genvar i = 0; i < DW; i++) begin : g_lane
    state_t        st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]    ev;

    assign set_evt[i] = ev;

    // Lane state and hold counter
    always_ff @(posedge clk) begin
      if (rst) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        st  <= st_nxt;
        cnt <= cnt_nxt;
      end
    end

    // Lane next state and event strobes; only en_i ticks advance anything, release checked first
    always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      ev      = '0;
      cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      if (en_i) begin
        unique case (st)
          IDLE: if (in[i]) begin
            ev[0]   = 1'b1;
            cnt_nxt = '0;
            st_nxt  = DOWN;
          end
          DOWN: if (!in[i]) begin
            ev[1]  = 1'b1;
            st_nxt = IDLE;
          end else if (cnt_inc == LONG_C) begin
            ev[2]   = 1'b1;
            cnt_nxt = '0;
            st_nxt  = HELD;
          end else begin
            cnt_nxt = cnt_inc;
          end
          HELD: if (!in[i]) begin
            ev[1]  = 1'b1;
            st_nxt = IDLE;
`ifdef BTN_EVT_REPEAT_EN
          end else if (cnt_inc == REP_C) begin
            ev[3]   = 1'b1;
            cnt_nxt = '0;
`endif
          end else begin
            cnt_nxt = cnt_inc;
          end
          default: st_nxt = IDLE;
        endcase
      end
    end
  end

  logic             load, found, drop;
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       sel_type;

  assign load = !evt_valid || evt_ready;
  assign drop = |(set_evt & pend & ~clr);

  // Pick the lowest pending {bit, type}; the descending scan leaves the lowest match last
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_type = '0;
    clr      = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      for (int t = 3; t >= 0; t--) begin
        if (pend[i][t]) begin
          found    = 1'b1;
          sel_idx  = IDX_W'(i);
          sel_type = 2'(t);
        end
      end
    end
    if (load && found) clr[sel_idx][sel_type] = 1'b1;
  end

  // Pending flags: a new event wins over a same-cycle drain of the same flag
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr) | set_evt;
  end

  // Output register, reloaded whenever the consumer is not stalling it
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_type  <= '0;
    end else if (load) begin
      evt_valid <= found;
      if (found) begin
        evt_idx  <= sel_idx;
        evt_type <= sel_type;
      end
    end
  end

  // Sticky overflow; a fresh drop beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst)            ovf_o <= 1'b0;
    else if (drop)      ovf_o <= 1'b1;
    else if (ovf_clr_i) ovf_o <= 1'b0;
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen (DW=4, LONG=4, REPEAT=2). A duration-based
// reference model predicts the presented event and the ovf flag on every cycle.
module tb_button_event_gen;
  localparam int DW = 4;
  localparam int LP = 4;
  localparam int RP = 2;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_i = 1'b0;
  logic [DW-1:0] btn = '0;
  logic          evt_ready = 1'b1;
  logic          ovf_clr_i = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_idx;
  logic [1:0]    evt_type;
  logic          ovf_o;

  int nvec = 0;
  int nerr = 0;

  button_event_gen #(.DW(DW), .LONG_PRESS_COUNT(LP), .REPEAT_COUNT(RP)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .in(btn), .evt_ready(evt_ready),
    .ovf_clr_i(ovf_clr_i), .evt_valid(evt_valid), .evt_idx(evt_idx),
    .evt_type(evt_type), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: press state and ticks held since the press, per button
  bit             m_pr [DW];
  int             m_dur [DW];
  bit [DW-1:0][3:0] m_pend;
  bit             m_v, m_ovf;
  bit [1:0]       m_idx, m_typ;

  task automatic model_edge();
    bit [DW-1:0][3:0] set, clr;
    bit found;
    if (rst) begin
      for (int i = 0; i < DW; i++) begin m_pr[i] = 0; m_dur[i] = 0; end
      m_pend = '0; m_v = 0; m_idx = 0; m_typ = 0; m_ovf = 0;
      return;
    end
    set = '0; clr = '0; found = 0;
    if (en_i) begin
      for (int i = 0; i < DW; i++) begin
        if (!m_pr[i] && btn[i]) begin
          set[i][0] = 1; m_pr[i] = 1; m_dur[i] = 0;
        end else if (m_pr[i] && !btn[i]) begin
          set[i][1] = 1; m_pr[i] = 0;
        end else if (m_pr[i]) begin
          m_dur[i]++;
          if (m_dur[i] == LP) set[i][2] = 1;
          else if (REP && m_dur[i] > LP && (m_dur[i] - LP) % RP == 0) set[i][3] = 1;
        end
      end
    end
    if (!m_v || evt_ready) begin
      for (int i = 0; i < DW; i++)
        for (int t = 0; t < 4; t++)
          if (m_pend[i][t] && !found) begin
            found = 1; m_idx = 2'(i); m_typ = 2'(t); clr[i][t] = 1;
          end
      m_v = found;
    end
    if (|(set & m_pend & ~clr)) m_ovf = 1;
    else if (ovf_clr_i)         m_ovf = 0;
    m_pend = (m_pend & ~clr) | set;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [5:0] dut_vec();
    return {evt_valid, evt_idx, evt_type, ovf_o};
  endfunction

  function automatic logic [5:0] mdl_vec();
    return {m_v, m_idx, m_typ, m_ovf};
  endfunction

  task automatic test_reset();
    rst = 1; en_i = 1; btn = '1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      nvec++;
      if (dut_vec() !== 6'b0) begin
        nerr++; $display("FAIL reset c%0d: got %b want 000000", c, dut_vec());
      end
    end
    btn = '0; rst = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL reset_idle c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_short_press();
    logic [3:0] acc[$];
    evt_ready = 1; en_i = 1;
    for (int c = 0; c < 10; c++) begin
      btn = (c < 2) ? 4'b0100 : 4'b0000;
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL short c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (evt_valid && evt_ready) acc.push_back({evt_idx, evt_type});
    end
    nvec++;
    if (acc.size() != 2 || acc[0] !== 4'b1000 || acc[1] !== 4'b1001 || ovf_o !== 1'b0) begin
      nerr++; $display("FAIL short_seq: got %0d events ovf=%b want (2,P),(2,R) ovf=0", acc.size(), ovf_o);
    end
  endtask

  task automatic test_long_repeat();
    logic [3:0] acc[$];
    logic [3:0] exp[$];
    bit bad;
    exp = REP ? '{4'b0000, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001}
              : '{4'b0000, 4'b0010, 4'b0001};
    for (int c = 0; c < 20; c++) begin
      btn = (c < 11) ? 4'b0001 : 4'b0000;
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL long c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (evt_valid && evt_ready) acc.push_back({evt_idx, evt_type});
    end
    bad = (acc.size() != exp.size());
    for (int k = 0; k < acc.size() && !bad; k++) if (acc[k] !== exp[k]) bad = 1;
    nvec++;
    if (bad) begin
      nerr++; $display("FAIL long_seq: got %0d events want %0d", acc.size(), exp.size());
    end
  endtask

  task automatic test_simul();
    logic [3:0] acc[$];
    int         at[$];
    for (int c = 0; c < 10; c++) begin
      btn = (c < 3) ? 4'b1010 : 4'b0000;
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL simul c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (evt_valid && evt_ready) begin acc.push_back({evt_idx, evt_type}); at.push_back(c); end
    end
    nvec++;
    if (acc.size() < 2 || acc[0] !== 4'b0100 || acc[1] !== 4'b1100 || at[1] - at[0] != 1) begin
      nerr++; $display("FAIL simul_order: got %0d events, want (1,P) then (3,P) on consecutive cycles", acc.size());
    end
  endtask

  task automatic test_overflow();
    evt_ready = 0;
    for (int c = 0; c < 10; c++) begin
      btn = (c < 6 && c % 2 == 0) ? 4'b0010 : 4'b0000;
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL ovf_fill c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
    end
    nvec++;
    if (dut_vec() !== 6'b1_01_00_1) begin
      nerr++; $display("FAIL ovf_hold: got %b want 101001", dut_vec());
    end
    evt_ready = 1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL ovf_drain c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
    end
    ovf_clr_i = 1;
    cyc();
    ovf_clr_i = 0;
    nvec++;
    if (ovf_o !== 1'b0 || dut_vec() !== mdl_vec()) begin
      nerr++; $display("FAIL ovf_clear: got %b want ovf=0 (%b)", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] acc[$];
    evt_ready = 0; btn = 4'b0001;
    for (int c = 0; c < 6; c++) cyc();
    rst = 1;
    cyc();
    rst = 0;
    nvec++;
    if (evt_valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
      nerr++; $display("FAIL rst_mid: got %b want valid=0", dut_vec());
    end
    evt_ready = 1;
    for (int c = 0; c < 12; c++) begin
      btn = (c < 4) ? 4'b0001 : 4'b0000;
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL rst_after c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (evt_valid && evt_ready) acc.push_back({evt_idx, evt_type});
    end
    nvec++;
    if (acc.size() < 1 || acc[0] !== 4'b0000) begin
      nerr++; $display("FAIL rst_fresh_press: got %0d events, want (0,P) first", acc.size());
    end
  endtask

  task automatic test_en_gating();
    int long_at = -1;
    for (int c = 0; c < 28; c++) begin
      en_i = (c % 3 == 0);
      btn  = (c < 20) ? 4'b0100 : 4'b0000;
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL en_gate c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (evt_valid && {evt_idx, evt_type} == 4'b1010 && long_at < 0) long_at = c;
    end
    en_i = 1;
    nvec++;
    if (long_at != 13) begin
      nerr++; $display("FAIL en_gate_long: LONG seen at cycle %0d, want 13", long_at);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) btn[$urandom_range(0, DW-1)] ^= 1'b1;
      en_i      = ($urandom_range(0, 3) != 0);
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr_i = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      cyc();
      nvec++;
      if (dut_vec() !== mdl_vec()) begin
        nerr++; $display("FAIL random c%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
    end
    rst = 0; ovf_clr_i = 0; evt_ready = 1; en_i = 1;
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_simul();
    test_overflow();
    test_reset_mid();
    test_en_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
